// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and execute hold.
// Optional stall/flush event counters are enabled with `define ID_EX_STATS_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wr_reg,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              stall
);

  logic hazard;
  logic bubble;

  // Only a load in EX can hazard; a destination of $0 is never really written.
  always_comb begin
    hazard = id_valid & ex_valid & ex_ctrl[1] & (ex_wr_reg != '0) &
             ((id_rs == ex_wr_reg) | (id_uses_rt & (id_rt == ex_wr_reg)));
    stall  = hazard | ex_hold;
    bubble = flush | hazard | ~id_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_wr_reg <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
    end else if (!ex_hold) begin
      if (bubble) begin
        ex_valid  <= 1'b0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_wr_reg <= '0;
        ex_rd1    <= '0;
        ex_rd2    <= '0;
        ex_imm    <= '0;
        ex_ctrl   <= '0;
      end else begin
        ex_valid  <= 1'b1;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_wr_reg <= id_wr_reg;
        ex_rd1    <= id_rd1;
        ex_rd2    <= id_rd2;
        ex_imm    <= id_imm;
        ex_ctrl   <= id_ctrl;
      end
    end
  end

`ifdef ID_EX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && !ex_hold && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && id_valid && !ex_hold && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode/register-read and execute in the 5-stage MIPS core.
- Captures Rs/Rt read data, the sign-extended immediate and decoded control bits from the register file and decoder.
- Detects load-use hazards and inserts bubbles.
- Honours branch flush and execute-stage hold.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
CTRL_W, 10, control bundle width: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [8:5] alu_op, [9] branch

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-low
id_valid  in  1  decode holds a real instruction
id_rs  in  REG_AW  source register 1
id_rt  in  REG_AW  source register 2
id_uses_rt  in  1  instruction reads Rt as an operand
id_wr_reg  in  REG_AW  destination, already rt/rd-selected
id_rd1  in  DATA_W  Read_Data_1 from register file
id_rd2  in  DATA_W  Read_Data_2 from register file
id_imm  in  DATA_W  sign-extended immediate
id_ctrl  in  CTRL_W  decoded control
flush  in  1  kill instruction currently in decode (branch taken)
ex_hold  in  1  execute busy, freeze this register
ex_valid  out  1  registered valid
ex_rs, ex_rt, ex_wr_reg  out  REG_AW  registered addresses
ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered operands
ex_ctrl  out  CTRL_W  registered control
stall  out  1  combinational; freeze PC and IF/ID

Behaviour:
- Reset: at a posedge with reset=0, every ex_* output is cleared to 0. Reset overrides hold and flush, including reset asserted mid-stall or mid-hold.
- Hazard detection, combinational:
  - hazard = id_valid & ex_valid & ex_ctrl[1] & (ex_wr_reg != 0) & ((id_rs == ex_wr_reg) | (id_uses_rt & id_rt == ex_wr_reg)).
  - stall = hazard | ex_hold.
- Update priority at each posedge with reset=1:
  1. ex_hold=1: all ex_* hold. Flush and hazard are ignored this cycle.
  2. Else if flush, hazard or !id_valid: load a bubble. All ex_* become 0.
  3. Else capture: each ex_* takes its corresponding id_* input.
- Latency: 1 cycle from decode to ex_*.
- Load-use penalty is exactly 1 bubble:
  - The bubble has mem_read=0, so hazard deasserts the following cycle.
  - The held ID instruction is captured one edge later.
- Register 0: a load targeting $0 never causes a stall.
- Register-file write-through forwarding is not duplicated here. Operands arrive already bypassed.
- flush and hazard together: a bubble is loaded. The upstream stages discard the decode instruction under flush.
- Outputs have no combinational path from id_* except stall.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- When defined, adds two output ports:
  - stall_cnt (32): increments on cycles with hazard=1 and ex_hold=0.
  - flush_cnt (32): increments on cycles with flush=1, id_valid=1 and ex_hold=0.
- Both counters saturate at 32'hFFFFFFFF and clear to 0 on reset.
- When undefined, these ports and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: reset=0 for one edge with random id_* inputs -> all ex_*=0 and stall=0.
- Capture: id_valid=1, rs=3, rt=4, wr=5, rd1=0x11, rd2=0x22, imm=0xFFFFFFF0, ctrl=0x001 -> next edge ex_* match exactly, ex_valid=1.
- Load-use: EX holds lw (ctrl[1]=1, wr=8); ID add with rs=8 -> stall=1 the same cycle; next edge ex_valid=0, ex_ctrl=0, stall=0; following edge the add is captured. With id_uses_rt=0 and rt=8 only -> no stall.
- $0 load: EX lw with wr=0, ID rs=0 -> stall=0, capture proceeds.
- Flush/hold: flush=1 with a valid instruction -> bubble. ex_hold=1 together with flush=1 for 3 cycles -> ex_* unchanged and stall=1. Reset=0 during hold -> all ex_* become 0.
- Stats (ID_EX_STATS_EN defined): two load-use stalls and one flush -> stall_cnt=2, flush_cnt=1. Forcing stall_cnt to 0xFFFFFFFF then another stall -> stall_cnt stays 0xFFFFFFFF.
